// File: rtl/dma_arbiter_pkg.sv
// Shared CPU package: bus word types, the OAM DMA state encoding and the DMA memory-map constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dma_arbiter_pkg;

  typedef logic [15:0] reg16_t;
  typedef logic [7:0]  reg8_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam reg16_t      DMA_REG  = 16'hFF46;  // DMA source page register
  localparam int unsigned DMA_LEN  = 160;       // bytes per OAM transfer
  localparam reg8_t       IDX_LAST = 8'(DMA_LEN - 1);
  localparam reg16_t      HRAM_LO  = 16'hFF80;
  localparam reg16_t      HRAM_HI  = 16'hFFFE;

  // Pages E0..FF alias the echo region, so they fold down by 0x20 onto work RAM.
  function automatic reg8_t eff_page(input reg8_t src);
    return (src >= 8'hE0) ? reg8_t'(src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/dma_arbiter_engine.sv
// OAM DMA sequencer: IDLE -> START (1 cycle) -> XFER (160 byte steps), restartable from any state.
// Latency: the first byte moves two cycles after start; each XFER cycle moves one byte.
// Backpressure: stall freezes idx for that cycle without leaving XFER.
// Ports: clk/rst (async active-low); start + src_in load a new transfer; stall holds progress;
//        active = START or XFER; xfer = XFER; idx/eff_hi form the source address; src for readback.
module oam_dma_engine
  import dma_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] src_in,
  input  logic       stall,
  output logic       active,
  output logic       xfer,
  output logic [7:0] idx,
  output logic [7:0] eff_hi,
  output logic [7:0] src
);

  dma_state_t state, state_nx;
  reg8_t      idx_nx, src_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DMA_IDLE;
      idx   <= 8'h00;
      src   <= 8'hFF;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      src   <= src_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    src_nx   = src;
    // A restart wins over everything, including the final byte of a transfer.
    if (start) begin
      src_nx   = src_in;
      idx_nx   = 8'h00;
      state_nx = DMA_START;
    end else begin
      case (state)
        DMA_START: state_nx = DMA_XFER;
        DMA_XFER: begin
          if (!stall) begin
            if (idx == IDX_LAST) begin
              idx_nx   = 8'h00;
              state_nx = DMA_IDLE;
            end else begin
              idx_nx = idx + 8'h01;
            end
          end
        end
        default: state_nx = DMA_IDLE;
      endcase
    end
  end

  assign active = (state == DMA_START) || (state == DMA_XFER);
  assign xfer   = (state == DMA_XFER);
  assign eff_hi = eff_page(src);

endmodule

// File: rtl/dma_arbiter.sv
// Shares one memory bus between the CPU and the OAM DMA engine; decodes the DMA register and HRAM.
// Latency: combinational bus muxing; DMA register writes take effect on the next edge.
// Backpressure: during XFER non-HRAM CPU accesses are dropped (reads return FF); HRAM/DMA_REG accesses stall the DMA.
// Ports: cpu_* request side; mem_* shared bus (same-cycle read data); oam_* write port; dma_active status.
module dma_arbiter
  import dma_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  logic       is_dma, is_hram, cpu_acc, stall, dma_owns, xfer;
  logic [7:0] idx, eff_hi, src;

  assign is_dma   = (cpu_addr == DMA_REG);
  assign is_hram  = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
  assign cpu_acc  = cpu_rd || cpu_wr;
  // Only HRAM and the DMA register stay reachable while the DMA runs; touching them steals the bus.
  assign stall    = xfer && cpu_acc && (is_hram || is_dma);
  assign dma_owns = xfer && !stall;

  oam_dma_engine u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (cpu_wr && is_dma),
    .src_in (cpu_wdata),
    .stall  (stall),
    .active (dma_active),
    .xfer   (xfer),
    .idx    (idx),
    .eff_hi (eff_hi),
    .src    (src)
  );

  always_comb begin
    // CPU pass-through; the DMA register is internal and never reaches the bus.
    mem_addr  = cpu_addr;
    mem_rd    = cpu_rd && !is_dma;
    mem_wr    = cpu_wr && !cpu_rd && !is_dma;
    mem_wdata = cpu_wdata;
    cpu_rdata = (cpu_rd && is_dma) ? src : mem_rdata;
    oam_wr    = 1'b0;
    oam_addr  = 8'h00;
    oam_wdata = 8'h00;
    if (dma_owns) begin
      mem_addr  = {eff_hi, idx};
      mem_rd    = 1'b1;
      mem_wr    = 1'b0;
      mem_wdata = 8'h00;
      cpu_rdata = 8'hFF;
      oam_wr    = 1'b1;
      oam_addr  = idx;
      oam_wdata = mem_rdata;
    end
  end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, one M-cycle per rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cpu_addr  in  16; cpu_rd  in  1; cpu_wr  in  1; cpu_wdata  in  8; cpu_rdata  out  8; the CPU memory request, one access per cycle.
REQ-004 SHALL have ports: mem_addr  out  16; mem_rd  out  1; mem_wr  out  1; mem_wdata  out  8; mem_rdata  in  8; the shared memory bus, with combinational (same-cycle) read data.
REQ-005 SHALL have ports: oam_addr  out  8; oam_wr  out  1; oam_wdata  out  8; dma_active  out  1 (high in START and XFER).
REQ-006 SHALL define constants: DMA_REG = 16'hFF46 (DMA source register); DMA_LEN = 160 (bytes per transfer); HRAM_LO = 16'hFF80; HRAM_HI = 16'hFFFE.

Function
REQ-007 SHALL implement the FSM states IDLE, START and XFER, with an 8-bit index idx and an 8-bit source register src.
REQ-008 On a CPU write to DMA_REG: src <= cpu_wdata, idx <= 0, state <= START. This SHALL happen from any state, so a write during XFER restarts the transfer.
REQ-009 A CPU write to DMA_REG SHALL NOT assert mem_wr; a CPU read of DMA_REG SHALL return src on cpu_rdata and SHALL NOT assert mem_rd.
REQ-010 START SHALL last exactly one cycle and then move to XFER; no OAM write occurs in START.
REQ-011 Effective source page: eff_hi = src - 8'h20 if src >= 8'hE0, else src.
REQ-012 In each XFER cycle where the DMA owns the bus: mem_addr = {eff_hi, idx}; mem_rd = 1; oam_addr = idx; oam_wdata = mem_rdata; oam_wr = 1; idx <= idx + 1.
REQ-013 When the OAM write with idx = DMA_LEN-1 (159) completes, the next state SHALL be IDLE and idx SHALL return to 0; exactly 160 OAM writes occur per uninterrupted transfer.
REQ-014 In IDLE and START, mem_* SHALL equal the cpu_* signals (except per REQ-009), and cpu_rdata = mem_rdata.
REQ-015 In XFER, a CPU access to HRAM_LO..HRAM_HI or DMA_REG SHALL win the bus that cycle: mem_* = cpu_*, oam_wr = 0, and idx holds. This is a DMA stall.
REQ-016 In XFER, all other CPU accesses SHALL be blocked: writes dropped (no mem_wr), reads return 8'hFF on cpu_rdata, and the DMA proceeds.
REQ-017 mem_rd and mem_wr SHALL never both be high in the same cycle.
REQ-018 Simultaneous events: a DMA_REG write in the cycle of the final (idx = 159) transfer SHALL take priority. The next state is START; that cycle's OAM write is not performed, because the CPU owns the bus per REQ-015.
REQ-019 oam_* outputs SHALL be 0 whenever oam_wr = 0.

Reset
REQ-020 While rst = 0 (asynchronous): state = IDLE, idx = 0, src = 8'hFF.
REQ-021 While rst = 0, outputs SHALL be: dma_active = 0; oam_wr = 0; oam_addr = 0; oam_wdata = 0; mem_* pass through per REQ-014.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer immediately, with no further OAM writes and no resume on release.

Structure
REQ-023 dma_state_t, DMA_REG, DMA_LEN, HRAM_LO and HRAM_HI SHALL live in the shared CPU package alongside reg16_t and the other shared types.
REQ-024 A single sub-module, oam_dma_engine, SHALL hold the FSM, idx, src and eff_hi. Its inputs are start/src_in/stall and its outputs are active/idx/eff_hi/xfer.
REQ-025 The top level SHALL contain only the address decode and the bus muxing.

Verification
REQ-026 Reset check: rst low, then high -> dma_active = 0, and a CPU read of FF46 returns 8'hFF.
REQ-027 Basic transfer: write FF46 = 8'hC1 -> one START cycle, then 160 XFER cycles. mem_addr steps C100..C19F, oam_addr steps 00..9F, then IDLE; the OAM contents match the source bytes.
REQ-028 Echo mapping: write FF46 = 8'hE3 -> mem_addr starts at C300.
REQ-029 Blocked CPU access: at idx = 10, CPU reads 8000 -> cpu_rdata = FF and idx = 11 next cycle. At idx = 10, CPU writes 8000 -> no mem_wr.
REQ-030 HRAM stall: at idx = 20, CPU writes FF90 = 8'h5A -> mem_wr to FF90 that cycle, no oam_wr, and idx = 20 next cycle. Total transfer duration becomes 161 XFER cycles.
REQ-031 Restart: at idx = 50, write FF46 = 8'hD0 -> next cycle is START with idx = 0, followed by 160 writes sourced from D000.
